// File: rtl/traffic_timer_pkg.sv
// Shared types and constants for the traffic-light interval timer.
//   interval_e : interval select codes driven by the traffic-light FSM
//   state_e    : timer controller states
//   DEF_*      : power-on interval values in seconds
package traffic_timer_pkg;

   typedef enum logic [1:0] {
      INT_BASE = 2'b00,
      INT_EXT  = 2'b01,
      INT_YEL  = 2'b10
   } interval_e;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      EXPIRED
   } state_e;

   localparam int unsigned DEF_VAL_W = 4;
   localparam int unsigned DEF_BASE  = 6;
   localparam int unsigned DEF_EXT   = 3;
   localparam int unsigned DEF_YEL   = 2;

   // Code 11 is not a distinct interval; it falls back to the base green time.
   function automatic logic [1:0] interval_index(input logic [1:0] sel);
      return (sel == 2'b11) ? 2'(INT_BASE) : sel;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator.
//   clk   : system clock
//   reset : synchronous, active-high
//   clr   : restart the count from 0 (used when the interval counter loads)
//   tick  : one-cycle pulse every DIV cycles, high while the count sits at DIV-1
module tick_prescaler #(
   parameter int unsigned DIV = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer and configuration controller for the traffic-light FSM.
// Counts the interval selected by intervalo in prescaled seconds and flags
// time_expired; holds the three programmable interval values.
// Optional feature macro: INTERVAL_PROG_EN enables the programming path
// (prog_* inputs, writable intervals, reprogram pulse). Without it the
// intervals are the fixed defaults and reprogram is tied low.
//   clk, reset    : clock, synchronous active-high reset
//   start_timer   : timer request level from the FSM
//   intervalo     : interval select (00 base, 01 ext, 10 yellow, 11 base)
//   prog_sel      : register to write (11 ignored)
//   prog_val      : value to write
//   prog_strobe   : write request level, acted on at its rising edge
//   time_expired  : interval elapsed
//   reprogram     : one-cycle pulse to the FSM reprogram input
//   count         : remaining seconds
//   busy          : counting in progress
module interval_timer_ctrl
   import traffic_timer_pkg::*;
#(
   parameter int unsigned DIV   = 50000000,
   parameter int unsigned VAL_W = DEF_VAL_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_timer,
   input  logic [1:0]       intervalo,
   input  logic [1:0]       prog_sel,
   input  logic [VAL_W-1:0] prog_val,
   input  logic             prog_strobe,
   output logic             time_expired,
   output logic             reprogram,
   output logic [VAL_W-1:0] count,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [VAL_W-1:0] count_q, count_d;
   logic             start_prev_q;
   logic             start_edge;
   logic             tick;
   logic             presc_clr;
   logic             prog_edge;
   logic [VAL_W-1:0] val_base, val_ext, val_yel;
   logic [VAL_W-1:0] load_val;

`ifdef INTERVAL_PROG_EN
   logic             strobe_prev_q;
   logic             reprogram_q;
   logic [VAL_W-1:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;

   assign prog_edge = prog_strobe && !strobe_prev_q && (prog_sel != 2'b11);

   always_comb begin
      base_d = base_q;
      ext_d  = ext_q;
      yel_d  = yel_q;
      if (prog_edge) begin
         case (prog_sel)
            INT_BASE: base_d = prog_val;
            INT_EXT:  ext_d  = prog_val;
            INT_YEL:  yel_d  = prog_val;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_prev_q <= 1'b0;
         reprogram_q   <= 1'b0;
         base_q        <= VAL_W'(DEF_BASE);
         ext_q         <= VAL_W'(DEF_EXT);
         yel_q         <= VAL_W'(DEF_YEL);
      end else begin
         strobe_prev_q <= prog_strobe;
         reprogram_q   <= prog_edge;
         base_q        <= base_d;
         ext_q         <= ext_d;
         yel_q         <= yel_d;
      end
   end

   assign val_base  = base_q;
   assign val_ext   = ext_q;
   assign val_yel   = yel_q;
   assign reprogram = reprogram_q;
`else
   logic unused_prog;

   assign unused_prog = ^{prog_sel, prog_val, prog_strobe};
   assign prog_edge   = 1'b0;
   assign val_base    = VAL_W'(DEF_BASE);
   assign val_ext     = VAL_W'(DEF_EXT);
   assign val_yel     = VAL_W'(DEF_YEL);
   assign reprogram   = 1'b0;
`endif

   tick_prescaler #(
      .DIV(DIV)
   ) u_tick_prescaler (
      .clk  (clk),
      .reset(reset),
      .clr  (presc_clr),
      .tick (tick)
   );

   assign start_edge = start_timer && !start_prev_q;

   always_comb begin
      case (interval_index(intervalo))
         INT_EXT: load_val = val_ext;
         INT_YEL: load_val = val_yel;
         default: load_val = val_base;
      endcase
   end

   // Priority: programming, then request drop, then (re)load, then counting.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      presc_clr = 1'b0;
      if (prog_edge) begin
         state_d = IDLE;
         count_d = '0;
      end else if (!start_timer) begin
         state_d = IDLE;
      end else if (start_edge) begin
         state_d   = COUNT;
         count_d   = load_val;
         presc_clr = 1'b1;
      end else begin
         case (state_q)
            COUNT: begin
               if (count_q == '0) begin
                  state_d = EXPIRED;
               end else if (tick) begin
                  count_d = count_q - VAL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         start_prev_q <= start_timer;
      end
   end

   assign time_expired = (state_q == EXPIRED);
   assign busy         = (state_q == COUNT);
   assign count        = count_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;

   localparam int unsigned DIV   = 4;
   localparam int unsigned VAL_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start_timer;
   logic [1:0]       intervalo;
   logic [1:0]       prog_sel;
   logic [VAL_W-1:0] prog_val;
   logic             prog_strobe;
   logic             time_expired;
   logic             reprogram;
   logic [VAL_W-1:0] count;
   logic             busy;

   int errors = 0;
   int checks = 0;
   // Reference model: current interval values in seconds.
   int model_val [3] = '{6, 3, 2};

   always #5 clk = ~clk;

   interval_timer_ctrl #(
      .DIV  (DIV),
      .VAL_W(VAL_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_timer (start_timer),
      .intervalo   (intervalo),
      .prog_sel    (prog_sel),
      .prog_val    (prog_val),
      .prog_strobe (prog_strobe),
      .time_expired(time_expired),
      .reprogram   (reprogram),
      .count       (count),
      .busy        (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_lookup(input logic [1:0] sel);
      return (sel == 2'b11) ? model_val[0] : model_val[sel];
   endfunction

   // Raise start with the given select and measure cycles from the cycle start
   // rises to the first cycle with time_expired high. Load completes at the
   // end of that cycle, and expiry is V*DIV+1 cycles after the load.
   task automatic run_interval(input logic [1:0] sel, input string tag);
      int v;
      int n;
      v = model_lookup(sel);
      intervalo   = sel;
      start_timer = 1'b1;
      step();
      chk({tag, " busy after start"}, 32'(busy), 32'd1);
      chk({tag, " loaded count"}, 32'(count), 32'(v));
      n = 1;
      while (!time_expired && n < 200) begin
         step();
         n++;
      end
      chk({tag, " expiry latency"}, 32'(n), 32'(v * DIV + 2));
      start_timer = 1'b0;
      step();
      chk({tag, " expired drop"}, 32'(time_expired), 32'd0);
      chk({tag, " busy drop"}, 32'(busy), 32'd0);
   endtask

`ifdef INTERVAL_PROG_EN
   task automatic prog(input logic [1:0] sel, input logic [VAL_W-1:0] val, input string tag);
      prog_sel    = sel;
      prog_val    = val;
      prog_strobe = 1'b1;
      step();
      chk({tag, " reprogram pulse"}, 32'(reprogram), 32'(sel != 2'b11));
      if (sel != 2'b11) begin
         chk({tag, " busy after write"}, 32'(busy), 32'd0);
         chk({tag, " count after write"}, 32'(count), 32'd0);
         model_val[sel] = int'(val);
      end
      prog_strobe = 1'b0;
      step();
      chk({tag, " reprogram end"}, 32'(reprogram), 32'd0);
   endtask
`endif

   initial begin
      int n;
      int pulses;
      reset       = 1'b1;
      start_timer = 1'b0;
      intervalo   = 2'b00;
      prog_sel    = 2'b00;
      prog_val    = '0;
      prog_strobe = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("reset expired", 32'(time_expired), 32'd0);
      chk("reset reprogram", 32'(reprogram), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset count", 32'(count), 32'd0);

      // Default timings.
      run_interval(2'b00, "base");
      run_interval(2'b10, "yellow");
      run_interval(2'b11, "sel11");
      run_interval(2'b01, "ext");

`ifdef INTERVAL_PROG_EN
      // Zero-length extension expires on the second cycle.
      prog(2'b01, 4'd0, "ext0");
      run_interval(2'b01, "ext zero");

      // Write mid-count aborts the count.
      intervalo   = 2'b00;
      start_timer = 1'b1;
      n = 0;
      step();
      while (count != 4'd3 && n < 100) begin
         step();
         n++;
      end
      chk("midcount reached 3", 32'(count), 32'd3);
      prog(2'b00, 4'd9, "midcount");
      chk("midcount idle with start held", 32'(busy), 32'd0);
      start_timer = 1'b0;
      step();
      run_interval(2'b00, "base9");

      // Ignored select.
      prog(2'b11, 4'd1, "sel11 write");
      run_interval(2'b00, "base after ignored");

      // Held strobe gives a single write.
      prog_sel    = 2'b10;
      prog_val    = 4'd5;
      prog_strobe = 1'b1;
      pulses      = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         pulses += int'(reprogram);
      end
      prog_strobe = 1'b0;
      step();
      pulses += int'(reprogram);
      chk("held strobe pulses", 32'(pulses), 32'd1);
      model_val[2] = 5;
      run_interval(2'b10, "yellow5");

      // Simultaneous strobe and start: programming wins.
      prog_sel    = 2'b01;
      prog_val    = 4'd4;
      intervalo   = 2'b01;
      prog_strobe = 1'b1;
      start_timer = 1'b1;
      step();
      chk("simul busy", 32'(busy), 32'd0);
      chk("simul reprogram", 32'(reprogram), 32'd1);
      model_val[1] = 4;
      prog_strobe = 1'b0;
      start_timer = 1'b0;
      step();
      chk("simul reprogram end", 32'(reprogram), 32'd0);
      run_interval(2'b01, "ext4");

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            prog(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rand prog");
         end
         run_interval(2'($urandom_range(0, 3)), "rand run");
      end
`else
      // Without programming, the strobe has no effect and start wins.
      prog_sel    = 2'b01;
      prog_val    = 4'd4;
      intervalo   = 2'b01;
      prog_strobe = 1'b1;
      start_timer = 1'b1;
      step();
      chk("simul busy", 32'(busy), 32'd1);
      chk("simul reprogram", 32'(reprogram), 32'd0);
      prog_strobe = 1'b0;
      start_timer = 1'b0;
      step();
      chk("simul reprogram end", 32'(reprogram), 32'd0);
      run_interval(2'b00, "base unchanged");
      run_interval(2'b01, "ext unchanged");

      for (int i = 0; i < 8; i++) begin
         prog_sel    = 2'($urandom_range(0, 3));
         prog_val    = 4'($urandom_range(0, 15));
         prog_strobe = 1'($urandom_range(0, 1));
         run_interval(2'($urandom_range(0, 3)), "rand run");
         chk("rand reprogram tied", 32'(reprogram), 32'd0);
         prog_strobe = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
